// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package seq_bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int ADJ_THRESHOLD = 4;
  localparam int ADJ_ADD       = 3;

  // Constant-evaluated at elaboration to size-check DIGITS against WIDTH.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seq_bin_to_bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit exceeds 4 (4-bit wrap).
module bcd_digit_adj
  import seq_bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i > BCD_DIGIT_W'(ADJ_THRESHOLD)) digit_o = digit_i + BCD_DIGIT_W'(ADJ_ADD);
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter, one operand bit per cycle; done pulses WIDTH cycles after accept.
// Define SEQ_BIN_TO_BCD_SIGNED_EN for two's-complement input with a sign output.
module seq_bin_to_bcd
  import seq_bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
  ,
  output logic                          sign
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
  localparam longint MAX_MAG = longint'(1) << (WIDTH - 1);
`else
  localparam longint MAX_MAG = (longint'(1) << WIDTH) - 1;
`endif

  if (WIDTH < 4 || pow10(DIGITS) <= MAX_MAG) begin : g_bad_cfg
    $error("seq_bin_to_bcd: DIGITS too small for WIDTH, or WIDTH < 4");
  end

  state_t             state_q;
  logic               ready_q, busy_q, done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [BCD_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   opnd_load_d;
  logic [WIDTH-1:0]   opnd_shift_d;
  logic [BCD_W-1:0]   scr_adj;
  logic [BCD_W-1:0]   scr_shift_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits and operand shift left together as one {digits, operand} register.
  always_comb begin
    scr_shift_d  = {scr_adj[BCD_W-2:0], opnd_q[WIDTH-1]};
    opnd_shift_d = {opnd_q[WIDTH-2:0], 1'b0};
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    opnd_load_d  = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
`else
    opnd_load_d  = bin;
`endif
  end

`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
  logic sign_pend_q, sign_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      opnd_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            opnd_q  <= opnd_load_d;
            scr_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
            sign_pend_q <= bin[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          opnd_q <= opnd_shift_d;
          scr_q  <= scr_shift_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scr_shift_d;
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
            sign_q  <= sign_pend_q;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
  assign sign  = sign_q;
`endif

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench: an 8-bit/3-digit and a 16-bit/5-digit converter, directed vectors plus a 16-bit model sweep.
module tb_seq_bin_to_bcd;

  typedef struct packed {
    logic [19:0] bcd;
    logic        sign;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] eb;
    logic        es;
    bit          hold;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, rdy8, busy8, done8, sign8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic        rst16, start16, rdy16, busy16, done16, sign16;
  logic [15:0] bin16;
  logic [19:0] bcd16;

  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  logic [11:0] last8;
  bit   fin8 = 0, fin16 = 0;
  vec_t vecs[9];

  seq_bin_to_bcd #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk   (clk),
    .rst   (rst8),
    .start (start8),
    .bin   (bin8),
    .ready (rdy8),
    .busy  (busy8),
    .done  (done8),
    .bcd   (bcd8)
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    ,
    .sign  (sign8)
`endif
  );

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk   (clk),
    .rst   (rst16),
    .start (start16),
    .bin   (bin16),
    .ready (rdy16),
    .busy  (busy16),
    .done  (done16),
    .bcd   (bcd16)
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    ,
    .sign  (sign16)
`endif
  );

`ifndef SEQ_BIN_TO_BCD_SIGNED_EN
  assign sign8  = 1'b0;
  assign sign16 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model16(input logic [15:0] b);
    int   v;
    exp_t e;
    e = '0;
    v = int'(b);
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    if (b[15]) begin
      v = 65536 - v;
      e.sign = 1'b1;
    end
`endif
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return e;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst8 && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: got bcd=%h with no conversion outstanding", bcd8);
      end else begin
        e8 = q8.pop_front();
        if (bcd8 !== e8.bcd[11:0] || sign8 !== e8.sign) begin
          errors++;
          $display("FAIL result8: got sign=%b bcd=%h expected sign=%b bcd=%h",
                   sign8, bcd8, e8.sign, e8.bcd[11:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst16 && done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL done16_unexpected: got bcd=%h with no conversion outstanding", bcd16);
      end else begin
        e16 = q16.pop_front();
        if (bcd16 !== e16.bcd || sign16 !== e16.sign) begin
          errors++;
          $display("FAIL result16: got sign=%b bcd=%h expected sign=%b bcd=%h",
                   sign16, bcd16, e16.sign, e16.bcd);
        end
      end
    end
  end

  task automatic issue8(input logic [7:0] b, input logic [11:0] eb, input logic es, input bit hold);
    int n, nb;
    n = 0;
    while (!rdy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready8_before_start", 32'(rdy8), 32'd1);
    start8 = 1'b1;
    bin8   = b;
    q8.push_back('{bcd: {8'h00, eb}, sign: es});
    @(posedge clk);
    #1;
    if (!hold) start8 = 1'b0;
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
      if (n == 1) chk("bcd8_held_during_shift", 32'(bcd8), 32'(last8));
      if (hold && !done8) bin8 = ~bin8;
    end while (!done8 && n < 40);
    start8 = 1'b0;
    chk("latency8_negedges", n, 32'd9);
    chk("busy8_cycles", nb, 32'd8);
    @(negedge clk);
    chk("ready8_after_done", 32'(rdy8), 32'd1);
    last8 = eb;
  endtask

  task automatic issue16(input logic [15:0] b, input exp_t e);
    int n;
    n = 0;
    while (!rdy16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy16) chk("ready16_before_start", 32'(rdy16), 32'd1);
    start16 = 1'b1;
    bin16   = b;
    q16.push_back(e);
    @(posedge clk);
    #1;
    start16 = 1'b0;
    bin16   = ~b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 60);
    if (n != 17) chk("latency16_negedges", n, 32'd17);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    e = '{bcd: 20'h00001, sign: 1'b1};
`else
    e = '{bcd: 20'h65535, sign: 1'b0};
`endif
    rst16 = 1'b1; start16 = 1'b0; bin16 = '0;
    #1;
    chk("reset16_ready", 32'(rdy16), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst16 = 1'b0;
    issue16(16'hFFFF, e);
    chk("latency16_first", 32'(q16.size()), 32'd0);
    issue16(16'd0, model16(16'd0));
    issue16(16'd10000, model16(16'd10000));
    issue16(16'd9999, model16(16'd9999));
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      issue16(r, model16(r));
    end
    fin16 = 1;
  end

  initial begin
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    vecs = '{'{8'h80, 12'h128, 1'b1, 1'b0}, '{8'h00, 12'h000, 1'b0, 1'b0},
             '{8'd99, 12'h099, 1'b0, 1'b0}, '{8'd42, 12'h042, 1'b0, 1'b1},
             '{8'hFF, 12'h001, 1'b1, 1'b0}, '{8'h7F, 12'h127, 1'b0, 1'b0},
             '{8'd10, 12'h010, 1'b0, 1'b0}, '{8'h9C, 12'h100, 1'b1, 1'b0},
             '{8'd1,  12'h001, 1'b0, 1'b0}};
`else
    vecs = '{'{8'd255, 12'h255, 1'b0, 1'b0}, '{8'd0,   12'h000, 1'b0, 1'b0},
             '{8'd99,  12'h099, 1'b0, 1'b0}, '{8'd42,  12'h042, 1'b0, 1'b1},
             '{8'd100, 12'h100, 1'b0, 1'b0}, '{8'd9,   12'h009, 1'b0, 1'b0},
             '{8'd10,  12'h010, 1'b0, 1'b0}, '{8'd128, 12'h128, 1'b0, 1'b0},
             '{8'd199, 12'h199, 1'b0, 1'b0}};
`endif
    rst8 = 1'b1; start8 = 1'b0; bin8 = '0; last8 = '0;
    #1;
    chk("reset8_ready", 32'(rdy8), 32'd1);
    chk("reset8_busy", 32'(busy8), 32'd0);
    chk("reset8_done", 32'(done8), 32'd0);
    chk("reset8_bcd", 32'(bcd8), 32'd0);
    chk("reset8_sign", 32'(sign8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    foreach (vecs[i]) issue8(vecs[i].b, vecs[i].eb, vecs[i].es, vecs[i].hold);

    // Abort a conversion of 200 on its 4th SHIFT cycle; no result may appear.
    start8 = 1'b1;
    bin8   = 8'd200;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before_rst", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    #1;
    chk("abort_ready", 32'(rdy8), 32'd1);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_bcd", 32'(bcd8), 32'd0);
    chk("abort_sign", 32'(sign8), 32'd0);
    @(negedge clk);
    rst8  = 1'b0;
    last8 = '0;
    issue8(8'd37, 12'h037, 1'b0, 1'b0);
    fin8 = 1;
  end

  initial begin
    int n;
    n = 0;
    while (!(fin8 && fin16) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("stimulus_finished", 32'(fin8 && fin16), 32'd1);
    repeat (30) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_bin_to_bcd.md
SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

Interface
REQ-001 Parameter WIDTH, 8, binary operand width in bits (>=4).
REQ-002 Parameter DIGITS, 3, BCD output digit count; elaboration SHALL fail if 10**DIGITS <= 2**WIDTH-1.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  request to convert bin; sampled only when ready=1.
REQ-006 Port bin  input  WIDTH  binary operand, captured on the accepting edge.
REQ-007 Port ready  output  1  high in IDLE only.
REQ-008 Port busy  output  1  high while a conversion is in progress (SHIFT).
REQ-009 Port done  output  1  single-cycle pulse marking bcd valid.
REQ-010 Port bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0].
REQ-011 Port sign  output  1  present only with SEQ_BIN_TO_BCD_SIGNED_EN; 1 = operand negative.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE->SHIFT on start=1: load operand into shift register, clear digit scratch, load bit counter with WIDTH.
REQ-014 Each SHIFT cycle: add 3 to every scratch digit >4, then left-shift {digits, operand} by one bit, then decrement counter.
REQ-015 SHIFT->DONE when the counter reaches 0, after exactly WIDTH shift cycles.
REQ-016 In DONE: bcd gets the scratch digits, done=1 for that cycle only; DONE->IDLE unconditionally.
REQ-017 Latency: done high exactly WIDTH cycles after the start-accepting edge; throughput one conversion per WIDTH+2 cycles.
REQ-018 bcd (and sign) SHALL hold the last result until the next DONE; they do not change during SHIFT.
REQ-019 start while busy=1 or in DONE SHALL be ignored; no queuing, no effect on the current conversion.
REQ-020 Changes on bin after acceptance SHALL NOT affect the result.
REQ-021 Digit adjust SHALL be 4-bit modulo; the adjusted value is always <=12 before the shift, so no carry is lost.
REQ-022 bin=0 SHALL yield bcd=0 with normal latency (no early exit).

Reset
REQ-023 rst=1 SHALL immediately force IDLE, ready=1, busy=0, done=0, bcd=0, sign=0, counter=0, scratch=0.
REQ-024 Reset mid-conversion SHALL abort it without a done pulse; the first edge after deassertion may accept start.

Configuration
REQ-025 Macro SEQ_BIN_TO_BCD_SIGNED_EN defined: bin is two's complement; magnitude (-bin if MSB set) is converted; sign registered at acceptance, output with bcd; most-negative value converts correctly (WIDTH=8, -128 -> 128).
REQ-026 Macro undefined: bin is unsigned, sign port and logic absent, DIGITS check uses 2**WIDTH-1.

Structure
REQ-027 Package seq_bin_to_bcd_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), BCD_DIGIT_W=4 and ADJ_THRESHOLD=4/ADJ_ADD=3 constants.
REQ-028 Sub-module bcd_digit_adj (one 4-bit digit, add-3-if->4, combinational) SHALL be instantiated DIGITS times via generate.

Verification
REQ-029 WIDTH=8, bin=255, start pulse -> busy for 8 cycles, done 8 cycles after accept, bcd=0x255, ready back next cycle.
REQ-030 WIDTH=8, bin=0 then bin=99 back-to-back starts on ready -> bcd=0x000 then 0x099, each with one done pulse.
REQ-031 start held high and bin toggled during SHIFT -> single done, result matches bin at acceptance, no second conversion until ready.
REQ-032 rst asserted on 4th SHIFT cycle of bin=200 -> all outputs zero asynchronously, no done, next start bin=37 -> 0x037.
REQ-033 WIDTH=16, DIGITS=5, bin=65535 -> bcd=0x65535 after 16 cycles; random 1000-operand sweep matches reference model.
REQ-034 SEQ_BIN_TO_BCD_SIGNED_EN, WIDTH=8: bin=0x80 -> sign=1, bcd=0x128; bin=0xFF -> sign=1, bcd=0x001; bin=0x7F -> sign=0, bcd=0x127.
